// File: rtl/user_input_pulse_array.sv
`default_nettype none
// ============================================================================
// Module      : user_input_pulse_array
// Description : Per-channel conditioner for asynchronous user inputs such as
//               keys and switches. Each channel has a 2-flop synchroniser, a
//               debounce counter and a single-cycle pulse on every qualified
//               edge of the debounced level.
//               Optional auto-repeat: define USER_INPUT_AUTOREPEAT_EN to add a
//               hold counter per channel that emits repeat pulses while the
//               debounced level stays high.
// Ports       : clk   - system clock, all logic on posedge
//               rst   - synchronous reset, active-high
//               in    - [N_CH] raw asynchronous inputs, active-high
//               pulse - [N_CH] one-cycle pulse per qualified edge / repeat
//               level - [N_CH] debounced stable level
// Parameters  : N_CH, DEBOUNCE_CYCLES (>=1), EDGE_MODE (0 rise, 1 fall,
//               2 both), REPEAT_DELAY, REPEAT_PERIOD (>=1, auto-repeat only)
// Revision    : 1.0 - initial release
// ============================================================================
module user_input_pulse_array #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] level
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_cnt_w      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic               c_pulse_rise = (EDGE_MODE != 1);
    localparam logic               c_pulse_fall = (EDGE_MODE != 0);

`ifdef USER_INPUT_AUTOREPEAT_EN
    localparam int c_hold_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_hold_w   = $clog2(c_hold_max + 1);
    localparam logic [c_hold_w-1:0] c_delay  = c_hold_w'(REPEAT_DELAY);
    localparam logic [c_hold_w-1:0] c_period = c_hold_w'(REPEAT_PERIOD);
`endif

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1
        || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_param_check
        $error("user_input_pulse_array: illegal parameter value");
    end

    // ------------------------------------------------------------------------
    // Two-flop synchroniser; everything downstream looks only at r_s2.
    // ------------------------------------------------------------------------
    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel debounce, edge pulse and optional auto-repeat
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_lvl;
        logic               r_pls;
        logic               w_diff;
        logic               w_qual;
        logic               w_edge_ok;
        logic               w_rep_fire;

        // Synced sample disagrees with the stable level; the change is
        // accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
        assign w_diff    = r_s2[i] ^ r_lvl;
        assign w_qual    = w_diff && (r_cnt == c_cnt_last);
        // r_s2 is the level being adopted, so it tells rise from fall.
        assign w_edge_ok = r_s2[i] ? c_pulse_rise : c_pulse_fall;

`ifdef USER_INPUT_AUTOREPEAT_EN
        logic [c_hold_w-1:0] r_hold;
        logic [c_hold_w-1:0] w_hold_nxt;
        logic                r_rep_phase;   // 0: waiting for first repeat, 1: periodic

        assign w_hold_nxt = r_hold + 1'b1;
        // A qualifying edge while high is a fall; suppressing the repeat
        // there keeps edge and repeat pulses from ever coinciding.
        assign w_rep_fire = r_lvl && !w_qual
                            && (w_hold_nxt == (r_rep_phase ? c_period : c_delay));

        always_ff @(posedge clk) begin
            if (rst || !r_lvl || w_qual) begin
                r_hold      <= '0;
                r_rep_phase <= 1'b0;
            end else if (w_rep_fire) begin
                r_hold      <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_hold      <= w_hold_nxt;
            end
        end
`else
        assign w_rep_fire = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
                r_pls <= 1'b0;
            end else begin
                r_pls <= w_rep_fire;
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_qual) begin
                    r_lvl <= r_s2[i];
                    r_cnt <= '0;
                    r_pls <= w_edge_ok;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign pulse[i] = r_pls;
        assign level[i] = r_lvl;
    end

endmodule
`default_nettype wire

// File: tb/tb_user_input_pulse_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_input_pulse_array
// Description : Self-checking bench for user_input_pulse_array. Three copies
//               of the design (EDGE_MODE 0, 1 and 2) share one input bus and
//               are compared every cycle against a behavioural model built
//               from run lengths of synchronised samples and elapsed hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_input_pulse_array;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RP = 8;
`ifdef USER_INPUT_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic [N-1:0] in_v = '0;
    logic [N-1:0] p0, p1, p2, l0, l1, l2;
    logic [6*N-1:0] act;

    always #5 clk = ~clk;

    user_input_pulse_array #(.N_CH(N), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
        .clk(clk), .rst(rst), .in(in_v), .pulse(p0), .level(l0));
    user_input_pulse_array #(.N_CH(N), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
        .clk(clk), .rst(rst), .in(in_v), .pulse(p1), .level(l1));
    user_input_pulse_array #(.N_CH(N), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut2 (
        .clk(clk), .rst(rst), .in(in_v), .pulse(p2), .level(l2));

    assign act = {p0, p1, p2, l0, l1, l2};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    logic [N-1:0] m_lev = '0;
    logic [N-1:0] m_pulse [3];
    int           m_streak [N];   // consecutive synced samples differing from level
    int           m_since [N];    // cycles since rise pulse, -1 when not held

    function automatic logic [6*N-1:0] exp_vec();
        return {m_pulse[0], m_pulse[1], m_pulse[2], m_lev, m_lev, m_lev};
    endfunction

    task automatic model_step();
        logic e;
        logic rep;
        if (rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lev = '0;
            for (int c = 0; c < N; c++) begin
                m_streak[c] = 0;
                m_since[c]  = -1;
            end
            for (int m = 0; m < 3; m++) m_pulse[m] = '0;
        end else begin
            for (int m = 0; m < 3; m++) m_pulse[m] = '0;
            for (int c = 0; c < N; c++) begin
                e   = 1'b0;
                rep = 1'b0;
                if (m_s2[c] != m_lev[c]) begin
                    m_streak[c]++;
                    if (m_streak[c] == D) begin
                        e           = 1'b1;
                        m_lev[c]    = m_s2[c];
                        m_streak[c] = 0;
                    end
                end else begin
                    m_streak[c] = 0;
                end
                if (e) begin
                    m_since[c] = m_lev[c] ? 0 : -1;
                end else if (m_lev[c] && m_since[c] >= 0) begin
                    m_since[c]++;
                    rep = (m_since[c] == RD) || (m_since[c] > RD && (m_since[c] - RD) % RP == 0);
                end
                if (!AR) rep = 1'b0;
                for (int m = 0; m < 3; m++)
                    m_pulse[m][c] = (e && (m == 2 || ((m == 0) == m_lev[c]))) || rep;
            end
            m_s2 = m_s1;
            m_s1 = in_v;
        end
    endtask

    // Advance one clock, update model, then settle before sampling outputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst  = 1'b1;
        in_v = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (act !== '0) begin
                bad++;
                $display("FAIL reset cyc=%0d act=%h exp=0", cyc, act);
            end
        end
    endtask

    task automatic test_rise_after_reset();
        int first = -1;
        int cnt   = 0;
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL rise_model cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
            if (p0[0]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (first !== 6 || cnt !== 1) begin
            bad++;
            $display("FAIL rise_latency first=%0d count=%0d exp first=6 count=1", first, cnt);
        end
        total++;
        if (l0[0] !== 1'b1) begin
            bad++;
            $display("FAIL rise_level act=%b exp=1", l0[0]);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 15; k++) begin
            in_v[1] = (k < 3);
            tick();
            total++;
            if (act !== exp_vec() || p0[1] || p1[1] || p2[1] || l0[1] || l1[1] || l2[1]) begin
                bad++;
                $display("FAIL glitch cyc=%0d act=%h exp=%h (channel 1 all 0)", cyc, act, exp_vec());
            end
        end
    endtask

    task automatic test_both_edges();
        int t[$];
        int n0 = 0;
        int n1 = 0;
        for (int k = 0; k < 26; k++) begin
            in_v[2] = (k < 10);
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL both_model cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
            if (p2[2]) t.push_back(k);
            if (p0[2]) n0++;
            if (p1[2]) n1++;
        end
        total++;
        if (t.size() !== 2 || (t.size() == 2 && t[1] - t[0] != 10) || n0 !== 1 || n1 !== 1) begin
            bad++;
            $display("FAIL both_edges mode2_pulses=%0d mode0=%0d mode1=%0d exp 2 pulses 10 apart,1,1",
                     t.size(), n0, n1);
        end
    endtask

    task automatic test_all_channels();
        int hits  = 0;
        int other = 0;
        in_v = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL all_settle cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        in_v = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL all_model cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
            if (p0 == 4'b1111) hits++;
            else if (p0 != 4'b0000) other++;
        end
        total++;
        if (hits !== 1 || other !== 0) begin
            bad++;
            $display("FAIL all_channels full=%0d partial=%0d exp 1,0", hits, other);
        end
        in_v = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL all_release cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        int n = 0;
        in_v[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL mid_pre cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        rst = 1'b1;
        tick();
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL mid_reset cyc=%0d act=%h exp=0", cyc, act);
        end
        rst     = 1'b0;
        in_v[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL mid_post cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
            if (p0[3] || p1[3] || p2[3]) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL mid_nopulse count=%0d exp=0", n);
        end
    endtask

    task automatic test_autorepeat();
        int t[$];
        int exp_n;
        int exp_last;
        in_v[0] = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL repeat_model cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
            if (p0[0]) t.push_back(k);
        end
        in_v[0] = 1'b0;
        for (int k = 47; k <= 60; k++) begin
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL repeat_release cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
            if (p0[0]) t.push_back(k);
        end
        exp_n    = AR ? 5 : 1;
        exp_last = AR ? 46 : 6;
        total++;
        if (t.size() !== exp_n || t[0] !== 6 || t[t.size()-1] !== exp_last) begin
            bad++;
            $display("FAIL repeat_count count=%0d last=%0d exp count=%0d first=6 last=%0d",
                     t.size(), t.size() > 0 ? t[t.size()-1] : -1, exp_n, exp_last);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(3 + 8 * c, 0) == 0) in_v[c] = ~in_v[c];
            rst = ($urandom_range(199, 0) == 0);
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 3; m++) m_pulse[m] = '0;
        for (int c = 0; c < N; c++) begin
            m_streak[c] = 0;
            m_since[c]  = -1;
        end
        #2;
        test_reset();
        test_rise_after_reset();
        test_glitch();
        test_both_edges();
        test_all_channels();
        test_reset_mid_debounce();
        test_autorepeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
